axi_ddr_slave_responder: RTL
============================

// Module: axi_ddr_slave_responder
// PURPOSE
//  AXI4 slave-side responder (read + write) modelling the DDR4 that the Kalman
//  filter masters (initial-param reader, Zk reader, result writer) talk to.
//  Serves AR/R and AW/W/B channels from an internal beat-addressed RAM.
//  Used as the far end of one master port in system sim and FPGA loopback bring-up.
// PARAMETERS
//  ADDR_WIDTH     32             address width
//  DATA_WIDTH     512            data width; BEAT_BYTES = DATA_WIDTH/8 = 64
//  MEM_DEPTH      4096           RAM depth in beats (power of 2)
//  BASE_ADDR      32'h0030_0000  byte address of beat 0
//  READ_LATENCY   4              cycles from AR handshake to first rvalid (>=1)
//  BRESP_LATENCY  2              cycles from last W beat to bvalid (>=1)
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    async active-low reset
//  s_axi_araddr   in   32   read burst start byte address
//  s_axi_arlen    in   8    beats-1
//  s_axi_arsize   in   3    must equal log2(BEAT_BYTES) = 3'b110
//  s_axi_arburst  in   2    00 FIXED, 01 INCR, 10 WRAP (unsupported)
//  s_axi_arvalid  in   1    / s_axi_arready out 1 : AR handshake
//  s_axi_rdata    out  512  read beat data
//  s_axi_rresp    out  2    per-beat response
//  s_axi_rlast    out  1    last beat of burst
//  s_axi_rvalid   out  1    / s_axi_rready in 1 : R handshake
//  s_axi_awaddr/awlen/awsize/awburst/awvalid in, s_axi_awready out : as AR
//  s_axi_wdata    in   512  write beat data
//  s_axi_wstrb    in   64   byte enables
//  s_axi_wlast    in   1    master's last-beat marker
//  s_axi_wvalid   in   1    / s_axi_wready out 1 : W handshake
//  s_axi_bresp    out  2    burst response
//  s_axi_bvalid   out  1    / s_axi_bready in 1 : B handshake
//  rd_burst_cnt   out  16   completed read bursts (wraps at 2^16)
//  wr_burst_cnt   out  16   completed write bursts (wraps at 2^16)
// BEHAVIOUR
//  Reset: all ready/valid outputs, rlast, counters = 0; rdata = 0; rresp/bresp = OKAY.
//   RAM contents are not reset. Reset mid-burst aborts both FSMs to IDLE without a response.
//  Addressing: beat = (addr - BASE_ADDR) >> 6. In range iff 0 <= beat < MEM_DEPTH.
//   INCR: +1 beat per beat. FIXED: same beat for every beat. Each beat is range-checked.
//  Read FSM RD_IDLE -> RD_WAIT -> RD_DATA -> RD_IDLE.
//   RD_IDLE: arready=1; on arvalid&arready latch addr/len/size/burst, go to RD_WAIT.
//   RD_WAIT: count READ_LATENCY-1 cycles, then RD_DATA.
//    So the first rvalid is exactly READ_LATENCY cycles after the AR handshake.
//   RD_DATA: rvalid=1. rdata/rresp/rlast stay stable while rvalid&!rready.
//    The next beat is presented the cycle after a handshake; no bubbles.
//    rlast is set on beat arlen. A handshake with rlast=1 returns to RD_IDLE and
//    increments rd_burst_cnt. arready=0 outside RD_IDLE (one read burst outstanding).
//   rresp: SLVERR for the whole burst if arsize != 3'b110 or arburst == WRAP (rdata = 0).
//    Otherwise DECERR with rdata = 0 for out-of-range beats, OKAY for in-range beats.
//  Write FSM WR_IDLE -> WR_DATA -> WR_WAIT -> WR_RESP -> WR_IDLE.
//   WR_IDLE: awready=1; on handshake latch the AW fields.
//   WR_DATA: wready=1. Each handshake writes the bytes with wstrb=1 (others kept) and advances.
//    The burst ends on the beat with wlast=1, whatever the beat count.
//    On an early or late wlast (beat count != awlen+1): bresp=SLVERR; beats past awlen are dropped.
//   Burst-level errors (bad size/WRAP): all writes dropped, bresp=SLVERR.
//    Any out-of-range beat: beat dropped, bresp=DECERR (SLVERR takes priority).
//   WR_WAIT: BRESP_LATENCY-1 cycles. WR_RESP: bvalid=1 until bready.
//    On the handshake increment wr_burst_cnt and go to WR_IDLE.
//  Read and write run concurrently and independently.
//   A write and a read to the same beat in the same cycle: the read returns the old data (read-first).
//   A written beat is visible to any read beat fetched in a later cycle.
//  wvalid before the AW handshake: wready=0 and the beat is held off (no write-data FIFO).
// STRUCTURE
//  Package kalman_axi_pkg: AXI_BURST_FIXED/INCR/WRAP, AXI_RESP_OKAY/SLVERR/DECERR,
//   rd_state_t, wr_state_t enums, BEAT_BYTES/BEAT_SHIFT localparams.
//  Sub-module axi_resp_ram: 1W/1R synchronous RAM (MEM_DEPTH x DATA_WIDTH),
//   per-byte write enable, read-first.
//   The read port is fetched one beat ahead so back-to-back R beats need no bubble.
// TESTING
//  1. Single read: preload beat 0 = 'hA5.., AR addr=BASE arlen=0
//     -> rvalid at +4 cycles, rdata='hA5.., rlast=1, rresp=OKAY, rd_burst_cnt=1.
//  2. INCR write then read back: AW addr=BASE+0x40 awlen=3, wstrb all 1, data k+1, wlast on beat 3
//     -> bvalid 2 cycles after the last beat, bresp=OKAY; a 4-beat read returns 1..4 with rlast only on beat 3.
//  3. Backpressure: rready toggles 1-0-0-1 during a 4-beat read
//     -> rdata/rlast held while stalled; all beats delivered in order, none lost or duplicated.
//  4. Strobes and errors: wstrb=64'h0F over 'hFF.. -> only bytes 0-3 changed.
//     arsize=3'b101 -> all beats SLVERR with data 0.
//     Read at BASE+MEM_DEPTH*64-64 with arlen=1 -> OKAY then DECERR.
//  5. Protocol: wlast on beat 1 of an awlen=3 burst -> bresp=SLVERR, FSM back to idle, awready=1.
//     Simultaneous read/write to one beat -> the read returns old data.
//  6. Reset asserted mid 8-beat read -> rvalid=0 immediately; after release arready=1 and the RAM is intact.

Source files
------------

// File: rtl/kalman_axi_pkg.sv
// AXI encodings and FSM state types shared by the DDR responder
// model that sits behind the Kalman-filter master ports.
package kalman_axi_pkg;

    localparam int BEAT_BYTES = 64;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    localparam logic [2:0] AXI_SIZE_BEAT = 3'(BEAT_SHIFT);

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_WAIT,
        WR_RESP
    } wr_state_t;

    function automatic logic burst_bad(input logic [2:0] size,
                                       input logic [1:0] burst);
        return (size != AXI_SIZE_BEAT) || (burst == AXI_BURST_WRAP);
    endfunction

    // Beat pointer step; reserved encodings hold like FIXED
    function automatic logic burst_step(input logic [1:0] burst);
        logic step;
        unique case (burst)
            AXI_BURST_FIXED: step = 1'b0;
            AXI_BURST_INCR:  step = 1'b1;
            default:         step = 1'b0;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/axi_resp_ram.sv
// Beat-wide 1W/1R RAM with byte enables; a same-cycle read of the
// beat being written returns the previous contents.
module axi_resp_ram #(
    parameter int DEPTH = 4096,
    parameter int DW    = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic [DW-1:0]   i_wdata,
    input  logic            i_re,
    input  logic [AW-1:0]   i_raddr,
    output logic [DW-1:0]   o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_ddr_slave_responder.sv
// AXI4 slave standing in for DDR4: independent read and write FSMs
// serving bursts out of a beat-addressed RAM.
module axi_ddr_slave_responder
    import kalman_axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 512,
    parameter int                    MEM_DEPTH     = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h0030_0000,
    parameter int                    READ_LATENCY  = 4,
    parameter int                    BRESP_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [15:0]             rd_burst_cnt,
    output logic [15:0]             wr_burst_cnt
);

    localparam int MAW     = $clog2(MEM_DEPTH);
    localparam int BW      = ADDR_WIDTH - BEAT_SHIFT;
    localparam int RD_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam int WB_LAST = (BRESP_LATENCY > 1) ? BRESP_LATENCY - 2 : 0;

    function automatic logic [BW-1:0] beat_of(input logic [ADDR_WIDTH-1:0] a);
        return BW'((a - BASE_ADDR) >> BEAT_SHIFT);
    endfunction

    function automatic logic in_range(input logic [BW-1:0] b);
        return b < BW'(MEM_DEPTH);
    endfunction

    rd_state_t       r_rd_state, w_rd_next;
    logic [BW-1:0]   r_rd_beat, w_rd_fetch;
    logic [7:0]      r_rd_len, r_rd_cnt, r_rd_lat;
    logic            r_rd_err, r_rd_step;
    logic [15:0]     r_rd_bursts;
    logic            w_rlast, w_rd_wait_done, w_ram_re;

    wr_state_t       r_wr_state, w_wr_next;
    logic [BW-1:0]   r_wr_beat;
    logic [7:0]      r_wr_len, r_wr_cnt, r_wr_lat;
    logic            r_wr_step, r_wr_slv, r_wr_dec, r_wr_past;
    logic [15:0]     r_wr_bursts;
    logic            w_whs, w_wr_in, w_ram_we;

    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_rlast        = (r_rd_cnt == r_rd_len);
    assign w_rd_wait_done = (r_rd_lat == RD_LAST[7:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rd_state <= RD_IDLE;
        else        r_rd_state <= w_rd_next;
    end

    always_comb begin
        w_rd_next = r_rd_state;
        unique case (r_rd_state)
            RD_IDLE: if (s_axi_arvalid)
                w_rd_next = (READ_LATENCY > 1) ? RD_WAIT : RD_DATA;
            RD_WAIT: if (w_rd_wait_done) w_rd_next = RD_DATA;
            RD_DATA: if (s_axi_rready && w_rlast) w_rd_next = RD_IDLE;
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        s_axi_rresp   = AXI_RESP_OKAY;
        s_axi_rdata   = '0;
        unique case (r_rd_state)
            RD_IDLE: s_axi_arready = rst_n;
            RD_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = w_rlast;
                if (r_rd_err)                s_axi_rresp = AXI_RESP_SLVERR;
                else if (!in_range(r_rd_beat)) s_axi_rresp = AXI_RESP_DECERR;
                else                         s_axi_rdata = w_ram_rdata;
            end
            default: ;
        endcase
    end

    // The RAM output always holds the beat being presented; it is
    // refetched only when that beat is consumed, so stalls hold data
    always_comb begin
        w_rd_fetch = r_rd_beat;
        if (r_rd_state == RD_IDLE)      w_rd_fetch = beat_of(s_axi_araddr);
        else if (r_rd_state == RD_DATA) w_rd_fetch = r_rd_beat + BW'(r_rd_step);
    end

    assign w_ram_re =
        (r_rd_state == RD_IDLE && s_axi_arvalid && READ_LATENCY == 1) ||
        (r_rd_state == RD_WAIT && w_rd_wait_done) ||
        (r_rd_state == RD_DATA && s_axi_rready && !w_rlast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_beat   <= '0;
            r_rd_len    <= '0;
            r_rd_cnt    <= '0;
            r_rd_lat    <= '0;
            r_rd_err    <= 1'b0;
            r_rd_step   <= 1'b0;
            r_rd_bursts <= '0;
        end else begin
            if (r_rd_state == RD_IDLE && s_axi_arvalid) begin
                r_rd_beat <= w_rd_fetch;
                r_rd_len  <= s_axi_arlen;
                r_rd_cnt  <= '0;
                r_rd_lat  <= '0;
                r_rd_err  <= burst_bad(s_axi_arsize, s_axi_arburst);
                r_rd_step <= burst_step(s_axi_arburst);
            end
            if (r_rd_state == RD_WAIT) r_rd_lat <= r_rd_lat + 8'd1;
            if (r_rd_state == RD_DATA && s_axi_rready) begin
                if (w_rlast) begin
                    r_rd_bursts <= r_rd_bursts + 16'd1;
                end else begin
                    r_rd_cnt  <= r_rd_cnt + 8'd1;
                    r_rd_beat <= w_rd_fetch;
                end
            end
        end
    end

    assign w_whs    = (r_wr_state == WR_DATA) && s_axi_wvalid;
    assign w_wr_in  = in_range(r_wr_beat);
    assign w_ram_we = w_whs && !r_wr_slv && !r_wr_past && w_wr_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wr_state <= WR_IDLE;
        else        r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next = r_wr_state;
        unique case (r_wr_state)
            WR_IDLE: if (s_axi_awvalid) w_wr_next = WR_DATA;
            WR_DATA: if (w_whs && s_axi_wlast)
                w_wr_next = (BRESP_LATENCY > 1) ? WR_WAIT : WR_RESP;
            WR_WAIT: if (r_wr_lat == WB_LAST[7:0]) w_wr_next = WR_RESP;
            WR_RESP: if (s_axi_bready) w_wr_next = WR_IDLE;
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = AXI_RESP_OKAY;
        unique case (r_wr_state)
            WR_IDLE: s_axi_awready = rst_n;
            WR_DATA: s_axi_wready  = 1'b1;
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                if (r_wr_slv)      s_axi_bresp = AXI_RESP_SLVERR;
                else if (r_wr_dec) s_axi_bresp = AXI_RESP_DECERR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_beat   <= '0;
            r_wr_len    <= '0;
            r_wr_cnt    <= '0;
            r_wr_lat    <= '0;
            r_wr_step   <= 1'b0;
            r_wr_slv    <= 1'b0;
            r_wr_dec    <= 1'b0;
            r_wr_past   <= 1'b0;
            r_wr_bursts <= '0;
        end else begin
            if (r_wr_state == WR_IDLE && s_axi_awvalid) begin
                r_wr_beat <= beat_of(s_axi_awaddr);
                r_wr_len  <= s_axi_awlen;
                r_wr_cnt  <= '0;
                r_wr_lat  <= '0;
                r_wr_step <= burst_step(s_axi_awburst);
                r_wr_slv  <= burst_bad(s_axi_awsize, s_axi_awburst);
                r_wr_dec  <= 1'b0;
                r_wr_past <= 1'b0;
            end
            if (w_whs) begin
                r_wr_beat <= r_wr_beat + BW'(r_wr_step);
                if (!r_wr_past) r_wr_cnt <= r_wr_cnt + 8'd1;
                if (!r_wr_past && !w_wr_in) r_wr_dec <= 1'b1;
                // Beats beyond awlen are swallowed until the master's wlast
                if (s_axi_wlast) begin
                    if (r_wr_past || r_wr_cnt != r_wr_len) r_wr_slv <= 1'b1;
                end else if (r_wr_cnt == r_wr_len) begin
                    r_wr_past <= 1'b1;
                end
            end
            if (r_wr_state == WR_WAIT) r_wr_lat <= r_wr_lat + 8'd1;
            if (r_wr_state == WR_RESP && s_axi_bready)
                r_wr_bursts <= r_wr_bursts + 16'd1;
        end
    end

    assign rd_burst_cnt = r_rd_bursts;
    assign wr_burst_cnt = r_wr_bursts;

    axi_resp_ram #(
        .DEPTH (MEM_DEPTH),
        .DW    (DATA_WIDTH),
        .AW    (MAW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_beat[MAW-1:0]),
        .i_wstrb (s_axi_wstrb),
        .i_wdata (s_axi_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_rd_fetch[MAW-1:0]),
        .o_rdata (w_ram_rdata)
    );

endmodule
